// File: rtl/drbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : drbg_pkg
// Brief    : Shared widths and fetch-FSM encoding for the DRBG word buffer.
// Revision : 1.0
// ============================================================================
package drbg_pkg;

    localparam int DRBG_BLOCK_W = 256;
    localparam int DRBG_WORD_W  = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQUEST = 2'd1,
        FETCH_RELEASE = 2'd2
    } fetch_state_t;

endpackage : drbg_pkg
`default_nettype wire

// File: rtl/drbg_word_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : drbg_word_buffer_if
// Brief    : DRBG next/next_ready link plus the keystream word valid/ready link.
// Revision : 1.0
// ============================================================================
interface drbg_word_buffer_if #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 256
) ();

    logic               drbg_next;
    logic               drbg_next_ready;
    logic [BLOCK_W-1:0] drbg_random_bits;
    logic               word_valid;
    logic               word_ready;
    logic [WORD_W-1:0]  word;

    modport master (
        output drbg_next,
        input  drbg_next_ready,
        input  drbg_random_bits,
        output word_valid,
        input  word_ready,
        output word
    );

    modport slave (
        input  drbg_next,
        output drbg_next_ready,
        output drbg_random_bits,
        input  word_valid,
        output word_ready,
        input  word
    );

endinterface : drbg_word_buffer_if
`default_nettype wire

// File: rtl/drbg_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : drbg_fetch_ctrl
// Brief    : DRBG request FSM, next_ready rise detect and captured-block counter.
// Revision : 1.0
// ============================================================================
module drbg_fetch_ctrl
    import drbg_pkg::*;
(
    input  wire         clk,
    input  wire         reset,
    input  wire         enable,
    input  wire         init_ready,
    input  wire         slot_free,
    input  wire         next_ready,
    output logic        drbg_next,
    output logic        capture,
    output logic [15:0] blocks_fetched
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic         r_nr_q;
    logic         w_nr_rise;
    logic         w_capture;
    logic [15:0]  r_blocks_fetched;

    // r_nr_q resets high so a next_ready left over from before reset is not a new block
    assign w_nr_rise = next_ready & ~r_nr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= FETCH_RELEASE;
            r_nr_q           <= 1'b1;
            r_blocks_fetched <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_nr_q  <= next_ready;
            if (w_capture) begin
                r_blocks_fetched <= r_blocks_fetched + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            FETCH_IDLE: begin
                if (enable && init_ready && slot_free) begin
                    w_state_nxt = FETCH_REQUEST;
                end
            end
            FETCH_REQUEST: begin
                if (w_nr_rise) begin
                    w_capture   = 1'b1;
                    w_state_nxt = FETCH_RELEASE;
                end
            end
            FETCH_RELEASE: begin
                if (!next_ready) begin
                    w_state_nxt = FETCH_IDLE;
                end
            end
            default: w_state_nxt = FETCH_RELEASE;
        endcase
    end

    assign drbg_next      = (r_state == FETCH_REQUEST);
    assign capture        = w_capture;
    assign blocks_fetched = r_blocks_fetched;

endmodule : drbg_fetch_ctrl
`default_nettype wire

// File: rtl/drbg_word_buffer.sv
`default_nettype none
// ============================================================================
// Module   : drbg_word_buffer
// Brief    : Ring of DRBG blocks served LSB-word-first as keystream words.
// Revision : 1.0
// ============================================================================
module drbg_word_buffer
    import drbg_pkg::*;
#(
    parameter int WORD_W    = DRBG_WORD_W,
    parameter int BLOCK_W   = DRBG_BLOCK_W,
    parameter int NUM_SLOTS = 2
) (
    input  wire                                         clk,
    input  wire                                         reset,
    input  wire                                         enable,
    input  wire                                         drbg_init_ready,
    drbg_word_buffer_if.master                          bus,
    output logic [$clog2(NUM_SLOTS*(BLOCK_W/WORD_W)+1)-1:0] words_available,
    output logic                                        underflow,
    output logic [15:0]                                 blocks_fetched
);

    localparam int WPB       = BLOCK_W / WORD_W;
    localparam int c_PTR_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int c_WIDX_W  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int c_AVAIL_W = $clog2(NUM_SLOTS*WPB+1);

    localparam logic [c_AVAIL_W-1:0] c_WPB_A  = c_AVAIL_W'(WPB);
    localparam logic [c_AVAIL_W-1:0] c_ONE_A  = c_AVAIL_W'(1);
    localparam logic [c_WIDX_W-1:0]  c_LAST_W = c_WIDX_W'(WPB-1);

    logic [WPB-1:0][WORD_W-1:0] r_slot_data [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]       r_full;
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_WIDX_W-1:0]        r_widx;
    logic [c_AVAIL_W-1:0]       r_avail;
    logic                       r_underflow;

    logic                       w_capture;
    logic                       w_slot_free;
    logic                       w_valid;
    logic                       w_xfer;
    logic                       w_release_slot;
    logic [WPB-1:0][WORD_W-1:0] w_rd_block;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(NUM_SLOTS-1)) ? '0 : p + 1'b1;
    endfunction

    // In a ring the write slot is occupied only when every slot is occupied
    assign w_slot_free    = ~r_full[r_wr_ptr];
    assign w_valid        = r_full[r_rd_ptr];
    assign w_xfer         = w_valid & bus.word_ready;
    assign w_release_slot = w_xfer & (r_widx == c_LAST_W);
    assign w_rd_block     = r_slot_data[r_rd_ptr];

    drbg_fetch_ctrl u_fetch_ctrl (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .init_ready     (drbg_init_ready),
        .slot_free      (w_slot_free),
        .next_ready     (bus.drbg_next_ready),
        .drbg_next      (bus.drbg_next),
        .capture        (w_capture),
        .blocks_fetched (blocks_fetched)
    );

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_slot_data[r_wr_ptr] <= bus.drbg_random_bits;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_widx      <= '0;
            r_avail     <= '0;
            r_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_capture && (r_wr_ptr == c_PTR_W'(i))) begin
                    r_full[i] <= 1'b1;
                end else if (w_release_slot && (r_rd_ptr == c_PTR_W'(i))) begin
                    r_full[i] <= 1'b0;
                end
            end
            if (w_capture) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_xfer) begin
                if (r_widx == c_LAST_W) begin
                    r_widx   <= '0;
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end else begin
                    r_widx <= r_widx + 1'b1;
                end
            end
            r_avail <= r_avail + (w_capture ? c_WPB_A : '0) - (w_xfer ? c_ONE_A : '0);
            if (bus.word_ready && !w_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Gated by the full flag so word reads zero whenever nothing is presented
    assign bus.word_valid = w_valid;
    assign bus.word       = w_valid ? w_rd_block[r_widx] : '0;
    assign words_available = r_avail;
    assign underflow       = r_underflow;

endmodule : drbg_word_buffer
`default_nettype wire

// File: tb/tb_drbg_word_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_drbg_word_buffer
// Brief    : Directed bench with a DRBG model and an expected-word scoreboard.
// Revision : 1.0
// ============================================================================
module tb_drbg_word_buffer;

    localparam int WORD_W    = 32;
    localparam int BLOCK_W   = 256;
    localparam int NUM_SLOTS = 2;
    localparam int WPB       = BLOCK_W / WORD_W;
    localparam int AVAIL_W   = $clog2(NUM_SLOTS*WPB+1);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               drbg_init_ready = 1'b0;
    logic [AVAIL_W-1:0] words_available;
    logic               underflow;
    logic [15:0]        blocks_fetched;

    drbg_word_buffer_if #(.WORD_W(WORD_W), .BLOCK_W(BLOCK_W)) bus ();

    drbg_word_buffer #(
        .WORD_W    (WORD_W),
        .BLOCK_W   (BLOCK_W),
        .NUM_SLOTS (NUM_SLOTS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .drbg_init_ready (drbg_init_ready),
        .bus             (bus),
        .words_available (words_available),
        .underflow       (underflow),
        .blocks_fetched  (blocks_fetched)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          blk = 0;
    int          m_cnt = 0;
    int          m_hold = 0;
    int          n_next_rise = 0;
    int          n_xfer = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge bus.drbg_next) n_next_rise++;

    // DRBG model: next_ready 20 cycles after next rises, held until next falls (+ m_hold)
    initial begin
        bus.drbg_next_ready  = 1'b0;
        bus.drbg_random_bits = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.drbg_next_ready) begin
                if (!bus.drbg_next) begin
                    if (m_hold > 0) m_hold--;
                    else bus.drbg_next_ready = 1'b0;
                end
            end else if (bus.drbg_next) begin
                m_cnt++;
                if (m_cnt == 20) begin
                    for (int k = 0; k < WPB; k++) begin
                        bus.drbg_random_bits[k*WORD_W +: WORD_W] = 32'hA000_0000 + 32'(blk*16 + k);
                        exp_q.push_back(32'hA000_0000 + 32'(blk*16 + k));
                    end
                    blk++;
                    m_cnt = 0;
                    bus.drbg_next_ready = 1'b1;
                end
            end else begin
                m_cnt = 0;
            end
        end
    end

    // Sample 1 ns before the rising edge: a transfer happens on that edge
    always @(negedge clk) begin
        #4;
        if (!reset && bus.word_valid && bus.word_ready) begin
            n_xfer++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("stream_word", bus.word, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic do_reset(input logic init, input logic en);
        @(negedge clk);
        reset = 1'b1;
        bus.word_ready = 1'b0;
        enable = en;
        drbg_init_ready = init;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_blocks(input int n, input string tag);
        int cyc;
        cyc = 0;
        while (blocks_fetched != 16'(n) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(blocks_fetched), 32'(n));
    endtask

    initial begin
        int cyc;
        int bad;
        int base_rise;
        int base_xfer;

        // Reset state, then fill both slots with word_ready low
        bus.word_ready  = 1'b0;
        enable          = 1'b1;
        drbg_init_ready = 1'b1;
        #12;
        check("rst_next",      32'(bus.drbg_next), 32'd0);
        check("rst_valid",     32'(bus.word_valid), 32'd0);
        check("rst_word",      bus.word, 32'd0);
        check("rst_avail",     32'(words_available), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_blocks",    32'(blocks_fetched), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_blocks(2, "fill_blocks");
        repeat (40) @(negedge clk);
        check("full_next_rises", 32'(n_next_rise), 32'd2);
        check("full_next_low",   32'(bus.drbg_next), 32'd0);
        check("full_avail",      32'(words_available), 32'd16);
        check("full_blocks",     32'(blocks_fetched), 32'd2);
        check("full_word0",      bus.word, 32'hA000_0000);
        check("full_valid",      32'(bus.word_valid), 32'd1);

        // Free slot 0, drain slot 1 to its last word, then consume it on the capture edge
        bus.word_ready = 1'b1;
        repeat (15) @(negedge clk);
        bus.word_ready = 1'b0;
        check("pre_coincide_avail", 32'(words_available), 32'd1);
        cyc = 0;
        while (!bus.drbg_next_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("coincide_nr_seen", 32'(bus.drbg_next_ready), 32'd1);
        bus.word_ready = 1'b1;
        @(negedge clk);
        bus.word_ready = 1'b0;
        check("coincide_avail",  32'(words_available), 32'd8);
        check("coincide_blocks", 32'(blocks_fetched), 32'd3);
        check("coincide_valid",  32'(bus.word_valid), 32'd1);
        check("coincide_no_uf",  32'(underflow), 32'd0);

        // Continuous consumption outpaces the DRBG, so gaps with ready high occur
        bus.word_ready = 1'b1;
        repeat (150) @(negedge clk);
        bus.word_ready = 1'b0;
        check("stream_underflow", 32'(underflow), 32'd1);

        // Reset while a block is pending capture in REQUEST
        do_reset(1'b1, 1'b1);
        cyc = 0;
        while (!bus.drbg_next_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_in_request", 32'(bus.drbg_next), 32'd1);
        m_hold = 4;
        reset  = 1'b1;
        #1;
        exp_q.delete();
        check("abort_next_async", 32'(bus.drbg_next), 32'd0);
        check("abort_valid",      32'(bus.word_valid), 32'd0);
        check("abort_word",       bus.word, 32'd0);
        check("abort_avail",      32'(words_available), 32'd0);
        check("abort_underflow",  32'(underflow), 32'd0);
        check("abort_blocks",     32'(blocks_fetched), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("abort_nr_still_high", 32'(bus.drbg_next_ready), 32'd1);
        bad = 0;
        cyc = 0;
        while (bus.drbg_next_ready && cyc < 50) begin
            if (bus.drbg_next) bad++;
            @(negedge clk);
            cyc++;
        end
        check("abort_no_req_nr_high", 32'(bad), 32'd0);
        check("abort_nr_dropped",     32'(bus.drbg_next_ready), 32'd0);
        wait_blocks(1, "abort_next_block");
        check("abort_word_fresh", bus.word, exp_q[0]);

        // word_ready high before the DRBG is instantiated
        do_reset(1'b0, 1'b1);
        bus.word_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("uf_set",        32'(underflow), 32'd1);
        check("uf_valid_low",  32'(bus.word_valid), 32'd0);
        check("uf_no_request", 32'(bus.drbg_next), 32'd0);
        drbg_init_ready = 1'b1;
        cyc = 0;
        while (!bus.word_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("uf_valid_at_capture", 32'(blocks_fetched), 32'd1);
        repeat (12) @(negedge clk);
        check("uf_sticky", 32'(underflow), 32'd1);
        bus.word_ready = 1'b0;

        // enable dropped after the first block
        do_reset(1'b1, 1'b1);
        wait_blocks(1, "en_first_block");
        enable    = 1'b0;
        base_rise = n_next_rise;
        base_xfer = n_xfer;
        bus.word_ready = 1'b1;
        repeat (20) @(negedge clk);
        bus.word_ready = 1'b0;
        repeat (20) @(negedge clk);
        check("en_off_words",   32'(n_xfer - base_xfer), 32'd8);
        check("en_off_valid",   32'(bus.word_valid), 32'd0);
        check("en_off_no_next", 32'(n_next_rise - base_rise), 32'd0);
        enable = 1'b1;
        cyc = 0;
        while (n_next_rise == base_rise && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("en_resume_next", 32'(n_next_rise - base_rise), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_drbg_word_buffer
`default_nettype wire
